// File: rtl/lane_ser_pkg.sv
// Shared encodings for the multi-lane serializer: gen_speed codes, frame lengths, FSM states.
package lane_ser_pkg;

  localparam logic [1:0] GEN_SPD_8A  = 2'b00;
  localparam logic [1:0] GEN_SPD_132 = 2'b01;
  localparam logic [1:0] GEN_SPD_66  = 2'b10;
  localparam logic [1:0] GEN_SPD_8B  = 2'b11;

  localparam int unsigned FRAME_LEN_8   = 8;
  localparam int unsigned FRAME_LEN_66  = 66;
  localparam int unsigned FRAME_LEN_132 = 132;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } ser_state_t;

  function automatic int unsigned frame_len(input logic [1:0] gs);
    case (gs)
      GEN_SPD_132:            return FRAME_LEN_132;
      GEN_SPD_66:             return FRAME_LEN_66;
      GEN_SPD_8A, GEN_SPD_8B: return FRAME_LEN_8;
      default:                return FRAME_LEN_8;
    endcase
  endfunction

endpackage

// File: rtl/lane_ser_shift.sv
// One lane of the serializer: registered LSB-first shifter, bit 0 appears on the load edge.
// Output bit is forced to 0 whenever neither loading nor shifting, and on synchronous clear.
module lane_ser_shift #(
  parameter int WORD_W = 132
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word,
  output logic              tx_bit
);

  logic [WORD_W-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg   <= '0;
      tx_bit <= 1'b0;
    end else if (clr) begin
      sreg   <= '0;
      tx_bit <= 1'b0;
    end else if (load) begin
      tx_bit <= word[0];
      sreg   <= word >> 1;
    end else if (shift) begin
      tx_bit <= sreg[0];
      sreg   <= sreg >> 1;
    end else begin
      tx_bit <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_lane_serializer.sv
// Lockstep multi-lane serializer with one-deep holding register; first bit one cycle after accept.
// Optional saturating underrun counter when LANE_SER_UNDERRUN_CNT_EN is defined.
module multi_lane_serializer
  import lane_ser_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int WORD_W    = 132
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [1:0]                    gen_speed,
  input  logic [NUM_LANES*WORD_W-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_LANES-1:0]          lane_tx_out,
  output logic                          tx_valid,
  output logic                          scr_rst,
  output logic                          underrun
`ifdef LANE_SER_UNDERRUN_CNT_EN
  ,
  output logic [7:0]                    underrun_cnt
`endif
);

  localparam int CNT_W = $clog2(WORD_W);

  ser_state_t                  state, state_nxt;
  logic [NUM_LANES*WORD_W-1:0] hold_data;
  logic                        hold_full, hold_full_nxt;
  logic [CNT_W-1:0]            bit_cnt, bit_cnt_nxt;
  logic                        last_bit, load_now, accept, shift_en;
  logic                        tx_valid_nxt, scr_rst_nxt, underrun_nxt;

  // Holding register drains into the shifters either from idle or on the last bit (no gap).
  assign last_bit = (state == ST_SHIFT) && (bit_cnt == '0);
  assign load_now = enable && hold_full && ((state == ST_IDLE) || last_bit);
  assign in_ready = enable && (!hold_full || load_now);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    hold_full_nxt = hold_full;
    shift_en      = 1'b0;
    tx_valid_nxt  = 1'b0;
    scr_rst_nxt   = 1'b0;
    underrun_nxt  = 1'b0;
    if (!enable) begin
      state_nxt     = ST_IDLE;
      bit_cnt_nxt   = '0;
      hold_full_nxt = 1'b0;
    end else begin
      hold_full_nxt = accept || (hold_full && !load_now);
      if (load_now) begin
        state_nxt    = ST_SHIFT;
        bit_cnt_nxt  = CNT_W'(frame_len(gen_speed) - 1);
        tx_valid_nxt = 1'b1;
        scr_rst_nxt  = 1'b1;
      end else if (state == ST_SHIFT) begin
        if (last_bit) begin
          state_nxt    = ST_IDLE;
          underrun_nxt = 1'b1;
        end else begin
          shift_en     = 1'b1;
          bit_cnt_nxt  = bit_cnt - CNT_W'(1);
          tx_valid_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      tx_valid  <= 1'b0;
      scr_rst   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      hold_full <= hold_full_nxt;
      tx_valid  <= tx_valid_nxt;
      scr_rst   <= scr_rst_nxt;
      underrun  <= underrun_nxt;
      if (accept) hold_data <= in_data;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_ser_shift #(.WORD_W(WORD_W)) u_shift (
      .clk    (clk),
      .rst    (rst),
      .clr    (!enable),
      .load   (load_now),
      .shift  (shift_en),
      .word   (hold_data[k*WORD_W +: WORD_W]),
      .tx_bit (lane_tx_out[k])
    );
  end

`ifdef LANE_SER_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (underrun_nxt && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/multi_lane_serializer.md
MULTI_LANE_SERIALIZER -- requirements
Module: multi_lane_serializer

Interface
REQ-001 Parameter NUM_LANES, default 2, number of independent serial lanes sharing one word handshake.
REQ-002 Parameter WORD_W, default 132, parallel word width per lane; SHALL be >= 132.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 enable  in  1  serializer enable; low = synchronous flush.
REQ-006 gen_speed  in  2  generation select; sets frame length L per word.
REQ-007 in_data  in  NUM_LANES*WORD_W  lane k word at bits [k*WORD_W +: WORD_W].
REQ-008 in_valid  in  1  in_data valid.
REQ-009 in_ready  out  1  block accepts in_data this cycle.
REQ-010 lane_tx_out  out  NUM_LANES  serial bit per lane.
REQ-011 tx_valid  out  1  lane_tx_out carries a valid bit.
REQ-012 scr_rst  out  1  one-cycle pulse aligned with bit 0 of every word; resets downstream scrambler seed.
REQ-013 underrun  out  1  one-cycle pulse when a word ends with no next word buffered.

Function
REQ-014 L SHALL be 8 for gen_speed 00 and 11, 132 for 01, 66 for 10; only bits [L-1:0] of each lane word are sent.
REQ-015 Transfer SHALL occur on an edge where in_valid && in_ready; word stored in a one-deep holding register (hold_full).
REQ-016 in_ready SHALL be enable && (!hold_full || load_now), load_now = holding register moves to shifter this cycle.
REQ-017 FSM states IDLE, SHIFT; IDLE with hold_full -> load, go SHIFT; SHIFT on last bit: hold_full -> load (no gap), else -> IDLE.
REQ-018 Load SHALL copy the holding register to per-lane shifters, latch L from current gen_speed, set bit counter to L-1, clear hold_full unless refilled same edge.
REQ-019 Bits SHALL be sent LSB first, one per cycle, all lanes in lockstep; bit 0 registered on the load edge.
REQ-020 Latency: word accepted at edge k with shifter idle -> bit 0 on lane_tx_out after edge k+1.
REQ-021 tx_valid SHALL be 1 for exactly L cycles per word; back-to-back words give continuous tx_valid.
REQ-022 scr_rst SHALL be high only during the bit-0 cycle of each word.
REQ-023 underrun SHALL pulse in the cycle after the last bit when transitioning SHIFT -> IDLE with enable high.
REQ-024 gen_speed change mid-word SHALL take effect only at next load.
REQ-025 Outputs lane_tx_out, tx_valid SHALL be 0 whenever not in SHIFT.
REQ-026 enable low SHALL on next edge force IDLE, clear hold_full, shifters, counter, all outputs to 0; in_ready 0.

Reset
REQ-027 rst high SHALL asynchronously force IDLE, hold_full=0, counter=0, shifters=0, lane_tx_out=0, tx_valid=0, scr_rst=0, underrun=0.
REQ-028 rst mid-word SHALL drop the word; first word after release starts at bit 0 with scr_rst pulse.

Configuration
REQ-029 Macro LANE_SER_UNDERRUN_CNT_EN defined: extra output underrun_cnt (8 bits), increments on each underrun pulse, saturates at 255, cleared by rst only.
REQ-030 Macro undefined: no underrun_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-031 Package lane_ser_pkg SHALL hold gen_speed encoding constants, frame-length constants (8, 66, 132), FSM state typedef.
REQ-032 Per-lane shift register SHALL be sub-module lane_ser_shift, instantiated NUM_LANES times by generate; FSM, counter, holding register stay in top.
REQ-033 Counter width SHALL be $clog2(WORD_W).

Verification
REQ-034 gen_speed=00, NUM_LANES=2, lane0 word 0xA5, lane1 0x3C, single transfer -> lane0 1,0,1,0,0,1,0,1; lane1 0,0,1,1,1,1,0,0; tx_valid 8 cycles; scr_rst cycle 1; underrun after.
REQ-035 gen_speed=10, in_valid held high, three words -> 198 contiguous tx_valid cycles, scr_rst at cycles 0, 66, 132, no underrun until end.
REQ-036 gen_speed=01, in_valid high, hold full -> in_ready low until load edge, high on load cycle; no word lost or duplicated.
REQ-037 gen_speed switched 01->00 at bit 40 -> current word completes 132 bits; next word 8 bits.
REQ-038 enable dropped at bit 3, later rst pulsed mid-word -> outputs 0 next edge (enable) / immediately (rst); next word restarts at bit 0 with scr_rst.
REQ-039 LANE_SER_UNDERRUN_CNT_EN defined, 300 isolated words -> underrun_cnt saturates at 255.
